mem_port_arbiter: RTL and testbench

//  Two-requester round-robin arbiter for the single shared memory port (addr/cmd/wdata/rdata).

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Two-requester round-robin arbiter for one shared memory port. Requester 0
// is the CPU port and requester 1 is the DMA/loader or I/O master. Each
// accepted request becomes exactly one memory transaction. A registered FSM
// sequences the transaction: IDLE -> ISSUE -> (WAIT ->) IDLE.
//
// Handshake: a requester holds req (with we/addr/wdata stable) until it sees
// gnt. The request is taken in a cycle where req & gnt are both high. gnt is
// combinational and is only ever high in IDLE, one requester at a time. A
// request cannot be withdrawn once it has been taken. Read data comes back on
// the shared rdata bus, qualified by a one-cycle rvalid strobe for the owner.
//
// Ports
//   clk, reset           clock; asynchronous active-high reset
//   req0/1, we0/1        request and write-enable (1=write, 0=read)
//   addr0/1, wdata0/1    request address and write data
//   gnt0/1               combinational accept
//   rvalid0/1, rdata     read-return strobe and registered read data
//   mem_addr, mem_cmd    registered memory address and command
//                        (00 NONE, 01 READ, 10 WRITE)
//   mem_wdata            registered memory write data
//   mem_rdata            memory read data, valid RD_LAT cycles after READ
//   busy                 high whenever the FSM is not in IDLE
module mem_port_arbiter #(
    parameter int AW     = 9,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [1:0]    mem_cmd,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int CW = $clog2(RD_LAT + 1);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            last;      // owner of the most recent grant
    logic            own_q;     // owner of the transaction in flight
    logic            we_q;      // transaction in flight is a write
    logic [CW-1:0]   cnt;       // remaining WAIT cycles before read data is valid
    logic            pick0;
    logic            pick1;
    logic            accept;
    logic            rd_done;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = we_q ? IDLE : WAIT;
            WAIT:    if (rd_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: grant selection and status. On contention the requester
    // that did not win last time is served. Reset masks the grants so nothing
    // is accepted while reset is held, even though the state already reads IDLE.
    always_comb begin
        pick0     = req0 & (~req1 | last);
        pick1     = req1 & (~req0 | ~last);
        gnt0      = (state == IDLE) & ~reset & pick0;
        gnt1      = (state == IDLE) & ~reset & pick1;
        accept    = gnt0 | gnt1;
        sel_we    = gnt1 ? we1    : we0;
        sel_addr  = gnt1 ? addr1  : addr0;
        sel_wdata = gnt1 ? wdata1 : wdata0;
        rd_done   = (state == WAIT) && (cnt == '0);
        busy      = (state != IDLE);
    end

    // Transaction bookkeeping: owner, direction, fairness pointer, wait count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last  <= 1'b1;
            own_q <= 1'b0;
            we_q  <= 1'b0;
            cnt   <= '0;
        end else begin
            if (accept) begin
                last  <= gnt1;
                own_q <= gnt1;
                we_q  <= sel_we;
            end
            if (state == ISSUE && !we_q) begin
                cnt <= CW'(RD_LAT - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Memory-side registers. The command is loaded on the accept edge so it
    // is on the bus for exactly the ISSUE cycle; address and write data keep
    // their values afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_cmd   <= CMD_NONE;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_cmd <= CMD_NONE;
            if (accept) begin
                mem_cmd   <= sel_we ? CMD_WRITE : CMD_READ;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
        end
    end

    // Read return: capture memory data in the last WAIT cycle and strobe the
    // owner's rvalid for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata   <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            if (rd_done) begin
                rdata   <= mem_rdata;
                rvalid0 <= ~own_q;
                rvalid1 <= own_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int AW       = 9;
    localparam int DW       = 16;
    localparam int RD_LAT   = 1;
    localparam int RD_LAT_B = 3;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT (RD_LAT = 1) ----------------
    logic          r_req   [2];
    logic          r_we    [2];
    logic [AW-1:0] r_addr  [2];
    logic [DW-1:0] r_wdata [2];
    logic          gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    mem_cmd;

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_dut (
        .clk(clk), .reset(reset),
        .req0(r_req[0]), .req1(r_req[1]), .we0(r_we[0]), .we1(r_we[1]),
        .addr0(r_addr[0]), .addr1(r_addr[1]), .wdata0(r_wdata[0]), .wdata1(r_wdata[1]),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .mem_addr(mem_addr), .mem_cmd(mem_cmd), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // ---------------- second DUT (RD_LAT = 3) ----------------
    logic          b_req0 = 1'b0, b_req1 = 1'b0, b_we0 = 1'b0, b_we1 = 1'b0;
    logic [AW-1:0] b_addr0 = '0, b_addr1 = '0;
    logic [DW-1:0] b_wdata0 = '0, b_wdata1 = '0;
    logic          b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_busy;
    logic [DW-1:0] b_rdata, b_mem_wdata, b_mem_rdata;
    logic [AW-1:0] b_mem_addr;
    logic [1:0]    b_mem_cmd;

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT_B)) u_dut_b (
        .clk(clk), .reset(reset),
        .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
        .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1), .rdata(b_rdata),
        .mem_addr(b_mem_addr), .mem_cmd(b_mem_cmd), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // ---------------- check / report ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 26) return 16'hBEEF;
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    // ---------------- memory models seen by the DUTs ----------------
    logic [DW-1:0] mem_world [512];
    logic          rd_v [RD_LAT];
    logic [AW-1:0] rd_a [RD_LAT];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 512; i++) mem_world[i] <= init_val(i);
            for (int k = 0; k < RD_LAT; k++) rd_v[k] <= 1'b0;
        end else begin
            if (mem_cmd == 2'b10) mem_world[mem_addr] <= mem_wdata;
            rd_v[0] <= (mem_cmd == 2'b01);
            rd_a[0] <= mem_addr;
            for (int k = 1; k < RD_LAT; k++) begin
                rd_v[k] <= rd_v[k-1];
                rd_a[k] <= rd_a[k-1];
            end
        end
    end
    // Data is only meaningful exactly RD_LAT cycles after READ; junk otherwise.
    assign mem_rdata = rd_v[RD_LAT-1] ? mem_world[rd_a[RD_LAT-1]] : 16'hDEAD;

    logic [2:0]    b_pv = '0;
    logic [AW-1:0] b_pa [3];
    always @(posedge clk) begin
        b_pv    <= {b_pv[1:0], b_mem_cmd == 2'b01};
        b_pa[0] <= b_mem_addr;
        b_pa[1] <= b_pa[0];
        b_pa[2] <= b_pa[1];
    end
    assign b_mem_rdata = b_pv[2] ? ({7'b0, b_pa[2]} ^ 16'hA5A5) : 16'hDEAD;

    // ---------------- reference model + scoreboard (main DUT) ----------------
    // One transaction at a time: each accept fixes the cycle of its memory
    // command, its read return and the cycle the arbiter becomes free again.
    logic [DW-1:0] mem_ref [512];
    logic [DW-1:0] exp_q [$];
    int            obs_log [$];
    bit            took [2];
    int            cyc = 0;
    int            free_cyc = 0;
    int            iss_cyc = -1;
    int            rv_cyc = -1;
    bit            rv_own;
    bit            last_m;
    logic [1:0]    iss_cmd;
    logic [AW-1:0] iss_addr;
    logic [DW-1:0] iss_wd;
    logic [AW-1:0] exp_maddr;
    logic [DW-1:0] exp_mwd;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    e_cmd;
    bit            idle_m, g0, g1, own;

    always @(negedge clk) begin
        took[0] = 1'b0;
        took[1] = 1'b0;
        if (reset) begin
            check("rst_gnt0", gnt0, 0);
            check("rst_gnt1", gnt1, 0);
            check("rst_rvalid0", rvalid0, 0);
            check("rst_rvalid1", rvalid1, 0);
            check("rst_busy", busy, 0);
            check("rst_mem_cmd", mem_cmd, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_rdata", rdata, 0);
            check("rst_b_busy", b_busy, 0);
            for (int i = 0; i < 512; i++) mem_ref[i] = init_val(i);
            exp_q.delete();
            free_cyc  = cyc;
            iss_cyc   = -1;
            rv_cyc    = -1;
            last_m    = 1'b1;
            exp_maddr = '0;
            exp_mwd   = '0;
            exp_rdata = '0;
        end else begin
            if (cyc == iss_cyc) begin
                exp_maddr = iss_addr;
                exp_mwd   = iss_wd;
            end
            e_cmd = (cyc == iss_cyc) ? iss_cmd : 2'b00;
            if (cyc == rv_cyc && exp_q.size() > 0) exp_rdata = exp_q.pop_front();
            idle_m = (cyc >= free_cyc);
            g0 = idle_m && r_req[0] && (!r_req[1] || last_m);
            g1 = idle_m && r_req[1] && (!r_req[0] || !last_m);

            check("gnt0", gnt0, g0);
            check("gnt1", gnt1, g1);
            check("busy", busy, !idle_m);
            check("mem_cmd", mem_cmd, e_cmd);
            check("mem_addr", mem_addr, exp_maddr);
            check("mem_wdata", mem_wdata, exp_mwd);
            check("rvalid0", rvalid0, (cyc == rv_cyc) && !rv_own);
            check("rvalid1", rvalid1, (cyc == rv_cyc) && rv_own);
            check("rdata", rdata, exp_rdata);

            if (gnt0 || gnt1) obs_log.push_back(gnt1 ? 1 : 0);

            if (g0 || g1) begin
                own       = g1;
                last_m    = own;
                took[own] = 1'b1;
                iss_cyc   = cyc + 1;
                iss_cmd   = r_we[own] ? 2'b10 : 2'b01;
                iss_addr  = r_addr[own];
                iss_wd    = r_wdata[own];
                if (r_we[own]) begin
                    mem_ref[r_addr[own]] = r_wdata[own];
                    free_cyc = cyc + 2;
                end else begin
                    exp_q.push_back(mem_ref[r_addr[own]]);
                    rv_cyc   = cyc + RD_LAT + 2;
                    rv_own   = own;
                    free_cyc = cyc + RD_LAT + 2;
                end
            end
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_step(input int p_req, input int p_we, input bit allow_drop);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (took[i] || !r_req[i]) begin
                r_req[i]   = ($urandom_range(0, 99) < p_req);
                r_we[i]    = ($urandom_range(0, 99) < p_we);
                r_addr[i]  = ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom_range(0, 31));
                r_wdata[i] = 16'($urandom);
            end else if (allow_drop && $urandom_range(0, 31) == 0) begin
                r_req[i] = 1'b0;
            end
        end
    endtask

    task automatic set_req(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        r_req[i]   = 1'b1;
        r_we[i]    = we;
        r_addr[i]  = a;
        r_wdata[i] = d;
    endtask

    // Wait (bounded) for the model to record an accept for requester idx,
    // then drop that request at the start of the following cycle.
    task automatic wait_accept(input int idx);
        bit seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            #1;
            seen = took[idx];
        end
        check("accept_timeout", seen, 1);
        @(posedge clk);
        #1;
        r_req[idx] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        for (int i = 0; i < 2; i++) begin
            r_req[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle_cycles(2);

        // single read by requester 0 of the preloaded word
        set_req(0, 1'b0, 9'h01A, 16'h0);
        wait_accept(0);
        idle_cycles(4);

        // single write by requester 1 at the top address
        set_req(1, 1'b1, 9'h1FF, 16'h1234);
        wait_accept(1);
        idle_cycles(3);

        // contention: both hold reads, six transactions must alternate 0,1,...
        base = obs_log.size();
        set_req(0, 1'b0, 9'h003, 16'h0);
        set_req(1, 1'b0, 9'h1FF, 16'h0);
        for (int n = 0; n < 60 && obs_log.size() < base + 6; n++) drive_step(100, 0, 1'b0);
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        check("t4_count", obs_log.size() >= base + 6, 1);
        for (int k = 0; k < 6 && base + k < obs_log.size(); k++)
            check("t4_order", obs_log[base+k], k % 2);
        idle_cycles(6);

        // abort: reset lands in WAIT, no strobe may follow
        set_req(0, 1'b0, 9'h01A, 16'h0);
        wait_accept(0);              // now at the start of ISSUE
        @(posedge clk);              // start of WAIT
        #3 reset = 1'b1;
        #1 check("t5_busy_in_reset", busy, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle_cycles(3);
        set_req(1, 1'b0, 9'h01A, 16'h0);
        wait_accept(1);
        idle_cycles(4);

        // reset mid-cycle while req0 is pending kills the grant at once
        set_req(0, 1'b0, 9'h003, 16'h0);
        #2 reset = 1'b1;
        #1;
        check("t1_gnt0_in_reset", gnt0, 0);
        check("t1_gnt1_in_reset", gnt1, 0);
        check("t1_cmd_in_reset", mem_cmd, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        set_req(1, 1'b0, 9'h004, 16'h0);
        @(negedge clk);
        #1;
        check("t1_first_gnt0", gnt0, 1);
        check("t1_first_gnt1", gnt1, 0);
        @(posedge clk);
        #1 r_req[0] = 1'b0;
        wait_accept(1);
        idle_cycles(4);

        // RD_LAT=3 instance: accept -> rvalid five cycles later, no grant between
        b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 9'h055;
        b_req1 = 1'b1; b_we1 = 1'b0; b_addr1 = 9'h0AA;
        @(negedge clk);
        #1;
        check("t6_gnt0", b_gnt0, 1);
        check("t6_gnt1", b_gnt1, 0);
        @(posedge clk);
        #1 b_req0 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            check("t6_gnt0_low", b_gnt0, 0);
            check("t6_gnt1_low", b_gnt1, 0);
            check("t6_rv_early", b_rvalid0, 0);
            check("t6_busy", b_busy, 1);
        end
        @(negedge clk);
        #1;
        check("t6_rvalid0", b_rvalid0, 1);
        check("t6_rvalid1", b_rvalid1, 0);
        check("t6_rdata", b_rdata, 16'h0055 ^ 16'hA5A5);
        check("t6_gnt1_next", b_gnt1, 1);
        @(posedge clk);
        #1 b_req1 = 1'b0;

        // randomized traffic
        for (int n = 0; n < 400; n++) drive_step(60, 45, 1'b1);
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        idle_cycles(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
